// File: rtl/layer5_pool_pkg.sv
// Layer5 max-pool types: FSM state enum and signed lane-max helper.
// No ports; imported by lane_max2 and layer5_maxpool_writer.
`include "def.svh"

package layer5_pool_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam int MAXW = 64;
  localparam int FMAP_DEF = `LAYER6_WIDTH;
  localparam int DATA_W_DEF = `LAYER6_WEIGHT_INPUT_LENGTH;

  // Lanes are sign-extended to MAXW before the call,
  // so one function serves any lane width up to MAXW.
  // Returns 1 when a is the maximum of the pair.
  function automatic logic lane_max(
    input logic signed [MAXW-1:0] a,
    input logic signed [MAXW-1:0] b
  );
    return a >= b;
  endfunction

endpackage

// File: rtl/def.svh
// Shared network dimensions for the layer5/layer6 datapath.
// Included by the pool package and the pool writer.
`ifndef DEF_SVH
`define DEF_SVH
`define LAYER6_WIDTH 10
`define LAYER6_WEIGHT_INPUT_LENGTH 32
`endif

// File: rtl/layer5_maxpool_writer_lane_max2.sv
// Combinational per-lane signed max of two packed pixels.
// Ports: a, b (DATA_W packed pixels in), y (per-lane max out).
module lane_max2
  import layer5_pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam int NL = DATA_W / LANE_W;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    logic [LANE_W-1:0] al;
    logic [LANE_W-1:0] bl;
    logic signed [MAXW-1:0] ax;
    logic signed [MAXW-1:0] bx;

    assign al = a[i*LANE_W +: LANE_W];
    assign bl = b[i*LANE_W +: LANE_W];
    assign ax = MAXW'($signed(al));
    assign bx = MAXW'($signed(bl));
    assign y[i*LANE_W +: LANE_W] =
      lane_max(ax, bx) ? al : bl;
  end

endmodule

// File: rtl/layer5_maxpool_writer.sv
// 2x2 max-pool of a raster pixel stream, one registered write per window.
// Ports: clk, rst (async low), start, in_valid/in_data, busy, save_*, frame_done.
`include "def.svh"

module layer5_maxpool_writer
  import layer5_pool_pkg::*;
#(
  parameter int DATA_W = `LAYER6_WEIGHT_INPUT_LENGTH,
  parameter int LANE_W = 16,
  parameter int FMAP = `LAYER6_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              busy,
  output logic              save_enable,
  output logic [15:0]       save_row_addr,
  output logic [15:0]       save_col_addr,
  output logic [DATA_W-1:0] layer5_result_store_data_in,
  output logic              frame_done
);

  localparam int HALF = FMAP / 2;
  localparam int AW = (HALF > 1) ? $clog2(HALF) : 1;

  state_t state;
  state_t state_nx;

  logic [15:0]       r;
  logic [15:0]       c;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] lb [HALF];
  logic [DATA_W-1:0] m2;
  logic [DATA_W-1:0] m3;
  logic [AW-1:0]     lb_idx;
  logic              consume;
  logic              c_end;
  logic              last_px;

  assign lb_idx  = AW'(c >> 1);
  assign consume = (state == S_RUN) && in_valid;
  assign c_end   = (c == 16'(FMAP - 1));
  assign last_px = c_end && (r == 16'(FMAP - 1));

  lane_max2 #(
    .DATA_W(DATA_W),
    .LANE_W(LANE_W)
  ) u_max_a (
    .a(hold),
    .b(in_data),
    .y(m2)
  );

  lane_max2 #(
    .DATA_W(DATA_W),
    .LANE_W(LANE_W)
  ) u_max_b (
    .a(m2),
    .b(lb[lb_idx]),
    .y(m3)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The final write is registered on the consuming edge,
  // so entering DONE on that same edge aligns frame_done with it.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN:  if (consume && last_px) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r    <= '0;
      c    <= '0;
      hold <= '0;
      for (int i = 0; i < HALF; i++) lb[i] <= '0;
      save_enable                 <= 1'b0;
      save_row_addr               <= '0;
      save_col_addr               <= '0;
      layer5_result_store_data_in <= '0;
    end else begin
      save_enable                 <= 1'b0;
      save_row_addr               <= '0;
      save_col_addr               <= '0;
      layer5_result_store_data_in <= '0;
      if (state == S_IDLE && start) begin
        r <= '0;
        c <= '0;
      end else if (consume) begin
        if (c_end) begin
          c <= '0;
          r <= last_px ? '0 : r + 16'd1;
        end else begin
          c <= c + 16'd1;
        end
        unique case (1'b1)
          !c[0]: hold <= in_data;
          c[0] && !r[0]: lb[lb_idx] <= m2;
          c[0] && r[0]: begin
            save_enable                 <= 1'b1;
            save_row_addr               <= {1'b0, r[15:1]};
            save_col_addr               <= {1'b0, c[15:1]};
            layer5_result_store_data_in <= m3;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_layer5_maxpool_writer.sv
// Self-checking bench for layer5_maxpool_writer.
// FMAP=10, two 16-bit lanes; window-max reference model.
module tb_layer5_maxpool_writer;

  localparam int DW = 32;
  localparam int LW = 16;
  localparam int FM = 10;
  localparam int H  = FM / 2;
  localparam int NW = H * H;

  logic          clk;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          busy;
  logic          save_enable;
  logic [15:0]   save_row_addr;
  logic [15:0]   save_col_addr;
  logic [DW-1:0] store_data;
  logic          frame_done;

  layer5_maxpool_writer #(
    .DATA_W(DW),
    .LANE_W(LW),
    .FMAP(FM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .busy(busy),
    .save_enable(save_enable),
    .save_row_addr(save_row_addr),
    .save_col_addr(save_col_addr),
    .layer5_result_store_data_in(store_data),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [DW-1:0] pix [FM][FM];

  int          q_row[$];
  int          q_col[$];
  int          q_cyc[$];
  logic [DW-1:0] q_dat[$];
  bit          q_done[$];
  int          exp_cyc[$];
  int          done_cnt = 0;
  int          bad_idle = 0;

  int n_chk = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (save_enable) begin
      q_row.push_back(int'(save_row_addr));
      q_col.push_back(int'(save_col_addr));
      q_dat.push_back(store_data);
      q_cyc.push_back(cyc);
      q_done.push_back(frame_done);
    end else if (save_row_addr != 0 || save_col_addr != 0 || store_data != 0) begin
      bad_idle++;
    end
    if (frame_done) done_cnt++;
  end

  function automatic logic [DW-1:0] exp_pool(input int i, input int j);
    logic [DW-1:0] res;
    logic [DW-1:0] p;
    logic signed [LW-1:0] m;
    logic signed [LW-1:0] v;
    res = '0;
    for (int l = 0; l < DW / LW; l++) begin
      p = pix[2*i][2*j];
      m = p[l*LW +: LW];
      for (int di = 0; di < 2; di++)
        for (int dj = 0; dj < 2; dj++) begin
          p = pix[2*i+di][2*j+dj];
          v = p[l*LW +: LW];
          if (v > m) m = v;
        end
      res[l*LW +: LW] = m;
    end
    return res;
  endfunction

  task automatic clear_mon();
    q_row.delete();
    q_col.delete();
    q_dat.delete();
    q_cyc.delete();
    q_done.delete();
    exp_cyc.delete();
    done_cnt = 0;
    bad_idle = 0;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < FM; i++)
      for (int j = 0; j < FM; j++)
        pix[i][j] = {16'(i*10+j), 16'(i*10+j)};
  endtask

  task automatic fill_rand();
    for (int i = 0; i < FM; i++)
      for (int j = 0; j < FM; j++)
        pix[i][j] = $urandom;
  endtask

  task automatic send_frame(input int maxgap, input bit noise,
                            input bit poke, input int npix);
    int i;
    int j;
    int gap;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < npix; k++) begin
      i = k / FM;
      j = k % FM;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) begin
        in_valid = 1'b0;
        in_data = $urandom;
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = pix[i][j];
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if ((i % 2 == 1) && (j % 2 == 1)) exp_cyc.push_back(cyc + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = poke;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int t;
    int n;
    t = 0;
    while (done_cnt == 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (done_cnt !== 1) begin
      n_fail++;
      $display("FAIL %s done_count got %0d want 1", tag, done_cnt);
    end
    n_chk++;
    if (q_row.size() !== NW) begin
      n_fail++;
      $display("FAIL %s write_count got %0d want %0d", tag, q_row.size(), NW);
    end
    n_chk++;
    if (bad_idle !== 0) begin
      n_fail++;
      $display("FAIL %s idle_outputs_nonzero got %0d want 0", tag, bad_idle);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_after got %b want 0", tag, busy);
    end
    n = (q_row.size() < NW) ? q_row.size() : NW;
    for (int k = 0; k < n; k++) begin
      n_chk++;
      if (q_row[k] !== k / H || q_col[k] !== k % H) begin
        n_fail++;
        $display("FAIL %s addr[%0d] got (%0d,%0d) want (%0d,%0d)",
                 tag, k, q_row[k], q_col[k], k / H, k % H);
      end
      n_chk++;
      if (q_dat[k] !== exp_pool(k / H, k % H)) begin
        n_fail++;
        $display("FAIL %s data[%0d] got %h want %h",
                 tag, k, q_dat[k], exp_pool(k / H, k % H));
      end
      n_chk++;
      if (k < exp_cyc.size() && q_cyc[k] !== exp_cyc[k]) begin
        n_fail++;
        $display("FAIL %s latency[%0d] got cycle %0d want %0d",
                 tag, k, q_cyc[k], exp_cyc[k]);
      end
      n_chk++;
      if (q_done[k] !== (k == NW - 1)) begin
        n_fail++;
        $display("FAIL %s done_align[%0d] got %b want %b",
                 tag, k, q_done[k], (k == NW - 1));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, save_enable, frame_done, save_row_addr,
         save_col_addr, store_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b%b%b %h %h %h want all 0",
               busy, save_enable, frame_done,
               save_row_addr, save_col_addr, store_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || save_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got busy=%b se=%b want 0 0",
               busy, save_enable);
    end
  endtask

  task automatic test_uniform();
    fill_ramp();
    clear_mon();
    send_frame(0, 1'b0, 1'b0, FM * FM);
    check_frame("uniform");
    n_chk++;
    if (q_dat.size() > 0 && q_dat[0] !== {16'd11, 16'd11}) begin
      n_fail++;
      $display("FAIL uniform_first got %h want %h", q_dat[0], {16'd11, 16'd11});
    end
  endtask

  task automatic test_signed();
    logic [15:0] v;
    fill_rand();
    v = -16'sd5;   pix[0][0] = {v, v};
    v = -16'sd1;   pix[0][1] = {v, v};
    v = -16'sd300; pix[1][0] = {v, v};
    v = -16'sd2;   pix[1][1] = {v, v};
    clear_mon();
    send_frame(0, 1'b0, 1'b0, FM * FM);
    check_frame("signed");
    n_chk++;
    if (q_dat.size() == 0 || q_dat[0] !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL signed_window got %h want ffffffff",
               (q_dat.size() > 0) ? q_dat[0] : 32'h0);
    end
  endtask

  task automatic test_lanes();
    fill_rand();
    pix[0][0] = {-16'sd8, 16'sd7};
    pix[0][1] = {16'sd5, 16'sd3};
    pix[1][0] = {16'sd0, -16'sd4};
    pix[1][1] = {16'sd9, 16'sd2};
    clear_mon();
    send_frame(0, 1'b0, 1'b0, FM * FM);
    check_frame("lanes");
    n_chk++;
    if (q_dat.size() == 0 || q_dat[0] !== 32'h0009_0007) begin
      n_fail++;
      $display("FAIL lane_indep got %h want 00090007",
               (q_dat.size() > 0) ? q_dat[0] : 32'h0);
    end
  endtask

  task automatic test_stalls();
    fill_ramp();
    clear_mon();
    send_frame(3, 1'b0, 1'b0, FM * FM);
    check_frame("stalls");
  endtask

  task automatic test_random();
    fill_rand();
    clear_mon();
    send_frame(2, 1'b0, 1'b0, FM * FM);
    check_frame("random");
  endtask

  task automatic test_reset_mid();
    fill_ramp();
    clear_mon();
    send_frame(0, 1'b0, 1'b0, 37);
    n_chk++;
    if (q_row.size() !== 8 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_pre got writes=%0d busy=%b want 8 1",
               q_row.size(), busy);
    end
    rst = 1'b0;
    #1;
    n_chk++;
    if ({busy, save_enable, frame_done, save_row_addr,
         save_col_addr, store_data} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset got busy=%b se=%b fd=%b want 0",
               busy, save_enable, frame_done);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_mon();
    repeat (20) begin
      in_valid = 1'b1;
      in_data = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++;
    if (q_row.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_quiet got writes=%0d busy=%b want 0 0",
               q_row.size(), busy);
    end
    clear_mon();
    send_frame(0, 1'b0, 1'b0, FM * FM);
    check_frame("after_reset");
  endtask

  task automatic test_ignored();
    fill_rand();
    clear_mon();
    repeat (10) begin
      in_valid = 1'b1;
      in_data = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++;
    if (q_row.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_valid got writes=%0d busy=%b want 0 0",
               q_row.size(), busy);
    end
    send_frame(1, 1'b1, 1'b1, FM * FM);
    check_frame("ignored");
    repeat (10) begin
      in_valid = 1'b1;
      in_data = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_chk++;
    if (q_row.size() !== NW || done_cnt !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_start got writes=%0d done=%0d busy=%b want %0d 1 0",
               q_row.size(), done_cnt, busy, NW);
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_signed();
    test_lanes();
    test_stalls();
    test_random();
    test_reset_mid();
    test_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
